// File: rtl/nibble_serial_alu_ctrl.sv
// Serial WIDTH-bit add/subtract built around one 4-bit carry-lookahead slice,
// processed LSB nibble first with a start/busy/done handshake.
//   state   | meaning
//   st_idle | waiting for start; result and flags hold
//   st_run  | one nibble per cycle through the slice
module nibble_serial_alu_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic {st_idle, st_run} state_t;

    state_t           state, state_next;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_q, b_q;

    logic [3:0]       an, bn, g, p, sum;
    logic [4:0]       c;
    logic [WIDTH-1:0] res_next;
    logic             accept, last;

    assign accept = (state == st_idle) && start;
    assign last   = (idx == LAST);
    assign busy   = (state == st_run);

    // Lookahead carries expanded from generate/propagate, not rippled.
    always_comb begin
        an = a_q[4*idx +: 4];
        bn = b_q[4*idx +: 4];
        g  = an & bn;
        p  = an ^ bn;
        c[0] = carry;
        c[1] = g[0] | (p[0] & carry);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & carry);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & carry);
        sum  = p ^ c[3:0];
        res_next = result;
        res_next[4*idx +: 4] = sum;
    end

    always_comb begin
        state_next = state;
        case (state)
            st_idle: if (start) state_next = st_run;
            st_run:  if (last)  state_next = st_idle;
            default: state_next = st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= st_idle;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                // Subtract as A + ~B + 1: the +1 enters as the initial carry.
                a_q   <= a;
                b_q   <= sub ? ~b : b;
                carry <= sub;
                idx   <= '0;
            end else if (state == st_run) begin
                result <= res_next;
                carry  <= c[4];
                idx    <= idx + 1'b1;
                if (last) begin
                    cout <= c[4];
                    ovf  <= c[3] ^ c[4];
                    zero <= (res_next == '0);
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Self-checking bench for nibble_serial_alu_ctrl (WIDTH=16): directed table,
// multi-cycle corner sequences and randomized ops against an arithmetic model.
module tb_nibble_serial_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, cout, ovf, zero;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;

    nibble_serial_alu_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [15:0] x, y, r;
        logic        c, v, z;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain modulo arithmetic and sign rules.
    function automatic void model(input logic s, input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] r, output logic c, output logic v,
                                  output logic z);
        logic [16:0] t;
        if (!s) begin
            t = {1'b0, x} + {1'b0, y};
            r = t[15:0];
            c = t[16];
            v = (x[15] == y[15]) && (r[15] != x[15]);
        end else begin
            r = x - y;
            c = (x >= y);
            v = (x[15] != y[15]) && (r[15] != x[15]);
        end
        z = (r == 16'h0);
    endfunction

    // Issues one op; returns at the negedge where done is seen (or after timeout).
    task automatic do_op(input logic s, input logic [15:0] x, input logic [15:0] y,
                         output int lat);
        @(negedge clk);
        start = 1'b1; sub = s; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
        check("busy_after_accept", busy, 1);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy && done) check("busy_done_overlap", 1, 0);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [15:0] r, input logic c,
                                 input logic v, input logic z);
        check({tag, "_result"}, result, r);
        check({tag, "_cout"}, cout, c);
        check({tag, "_ovf"}, ovf, v);
        check({tag, "_zero"}, zero, z);
    endtask

    initial begin
        vec_t        vecs[8];
        int          lat;
        logic [15:0] er;
        logic        ec, ev, ez;
        int          last_done, overlap, ndone;
        logic        seen;

        vecs[0] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 16'h0F0F, 16'h00F1, 16'h1000, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check_outputs("rst", 16'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].s, vecs[i].x, vecs[i].y, lat);
            check($sformatf("vec%0d_latency", i), lat, 4);
            check_outputs($sformatf("vec%0d", i), vecs[i].r, vecs[i].c, vecs[i].v, vecs[i].z);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), done, 0);
            check($sformatf("vec%0d_hold", i), result, vecs[i].r);
        end

        // start during RUN is ignored
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 16'h1111; b = 16'h2222;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        check("ignored_start_done_seen", done, 1);
        check("ignored_start_result", result, 16'h3333);
        repeat (6) @(negedge clk);
        check("ignored_start_no_second", busy, 0);

        // Reset during the second RUN cycle
        start = 1'b1; a = 16'h0F0F; b = 16'h0101; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check_outputs("midrst", 16'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin @(negedge clk); if (done) seen = 1'b1; end
        check("midrst_no_done", seen, 0);
        do_op(1'b0, 16'h0001, 16'h0001, lat);
        check("after_rst_latency", lat, 4);
        check_outputs("after_rst", 16'h0002, 1'b0, 1'b0, 1'b0);

        // start held high: one op per 5 cycles
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 16'h00FF; b = 16'h0001;
        last_done = -1; overlap = 0; ndone = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (busy && done) overlap++;
            if (done) begin
                check("held_result", result, 16'h0100);
                if (last_done >= 0) check("held_period", cyc - last_done, 5);
                last_done = cyc;
                ndone++;
            end
        end
        start = 1'b0;
        check("held_overlap", overlap, 0);
        check("held_count", ndone >= 7, 1);
        repeat (8) @(negedge clk);

        // Randomized ops against the model
        for (int n = 0; n < 40; n++) begin
            logic        s;
            logic [15:0] x, y;
            s = 1'($urandom);
            x = 16'($urandom);
            y = (n % 8 == 0) ? x : 16'($urandom);
            model(s, x, y, er, ec, ev, ez);
            do_op(s, x, y, lat);
            check("rand_latency", lat, 4);
            check_outputs($sformatf("rand%0d", n), er, ec, ev, ez);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
